// File: rtl/ifid_buffer.sv
// rtl/ifid_buffer.sv - IF/ID boundary: aligns fetch PC with RAM data, one-entry hold buffer, flush drop.
// Optional IFID_BUBBLE_CNT_EN adds a saturating bubble_cnt output.
module ifid_buffer #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter logic [INST_W-1:0]  NOP_INST = '0
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              if_ice,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [ADDR_W-1:0] if_pc_plus_4,
  input  logic [INST_W-1:0] inst_rdata,
  input  logic [3:0]        stall,
  input  logic              flush,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_plus_4,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid
`ifdef IFID_BUBBLE_CNT_EN
  ,
  output logic [31:0]       bubble_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DROP} state_t;

  state_t            state_q, state_d;
  logic              req_pend_q, req_pend_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d, req_pc4_q, req_pc4_d;
  logic              hold_full_q, hold_full_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d, hold_pc4_q, hold_pc4_d;
  logic [INST_W-1:0] hold_inst_q, hold_inst_d;
  logic              id_valid_q, id_valid_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d, id_pc4_q, id_pc4_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic              stall_id;
  logic              ret_ok;
  logic              unused_stall;

  assign stall_id     = stall[2];
  assign unused_stall = ^{stall[3], stall[1:0]};
  // RAM data is only trusted when a request is pending and we are not discarding after a flush.
  assign ret_ok       = req_pend_q && (state_q != DROP);

  always_comb begin
    state_d     = state_q;
    req_pend_d  = if_ice && !flush;
    req_pc_d    = req_pc_q;
    req_pc4_d   = req_pc4_q;
    hold_full_d = hold_full_q;
    hold_pc_d   = hold_pc_q;
    hold_pc4_d  = hold_pc4_q;
    hold_inst_d = hold_inst_q;
    id_valid_d  = id_valid_q;
    id_pc_d     = id_pc_q;
    id_pc4_d    = id_pc4_q;
    id_inst_d   = id_inst_q;

    if (if_ice && !flush) begin
      req_pc_d  = if_pc;
      req_pc4_d = if_pc_plus_4;
    end

    if (flush) begin
      id_valid_d  = 1'b0;
      id_inst_d   = NOP_INST;
      hold_full_d = 1'b0;
      state_d     = req_pend_q ? DROP : IDLE;
    end else if (!stall_id) begin
      if (hold_full_q) begin
        id_valid_d  = 1'b1;
        id_pc_d     = hold_pc_q;
        id_pc4_d    = hold_pc4_q;
        id_inst_d   = hold_inst_q;
        hold_full_d = 1'b0;
        state_d     = RUN;
      end else if (ret_ok) begin
        id_valid_d = 1'b1;
        id_pc_d    = req_pc_q;
        id_pc4_d   = req_pc4_q;
        id_inst_d  = inst_rdata;
        state_d    = RUN;
      end else begin
        id_valid_d = 1'b0;
        id_inst_d  = NOP_INST;
        state_d    = IDLE;
      end
    end else begin
      // A return while the buffer is already full is a fetch-side protocol error; the older entry wins.
      if (ret_ok && !hold_full_q) begin
        hold_full_d = 1'b1;
        hold_pc_d   = req_pc_q;
        hold_pc4_d  = req_pc4_q;
        hold_inst_d = inst_rdata;
        state_d     = HOLD;
      end else if (state_q == DROP) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q     <= IDLE;
      req_pend_q  <= 1'b0;
      req_pc_q    <= '0;
      req_pc4_q   <= '0;
      hold_full_q <= 1'b0;
      hold_pc_q   <= '0;
      hold_pc4_q  <= '0;
      hold_inst_q <= '0;
      id_valid_q  <= 1'b0;
      id_pc_q     <= '0;
      id_pc4_q    <= '0;
      id_inst_q   <= NOP_INST;
    end else begin
      state_q     <= state_d;
      req_pend_q  <= req_pend_d;
      req_pc_q    <= req_pc_d;
      req_pc4_q   <= req_pc4_d;
      hold_full_q <= hold_full_d;
      hold_pc_q   <= hold_pc_d;
      hold_pc4_q  <= hold_pc4_d;
      hold_inst_q <= hold_inst_d;
      id_valid_q  <= id_valid_d;
      id_pc_q     <= id_pc_d;
      id_pc4_q    <= id_pc4_d;
      id_inst_q   <= id_inst_d;
    end
  end

  assign id_valid     = id_valid_q;
  assign id_pc        = id_pc_q;
  assign id_pc_plus_4 = id_pc4_q;
  assign id_inst      = id_inst_q;

`ifdef IFID_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!stall_id && !id_valid_d && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ifid_buffer.sv
// tb/tb_ifid_buffer.sv - scoreboard bench for ifid_buffer with a queue-based reference model.
module tb_ifid_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ice;
  logic [31:0] if_pc, if_pc_plus_4, inst_rdata;
  logic [3:0]  stall;
  logic        flush;
  logic [31:0] id_pc, id_pc_plus_4, id_inst;
  logic        id_valid;
`ifdef IFID_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  always #5 clk = ~clk;

  ifid_buffer dut (
    .cpu_clk_50M (clk),
    .cpu_rst     (rst),
    .if_ice      (if_ice),
    .if_pc       (if_pc),
    .if_pc_plus_4(if_pc_plus_4),
    .inst_rdata  (inst_rdata),
    .stall       (stall),
    .flush       (flush),
    .id_pc       (id_pc),
    .id_pc_plus_4(id_pc_plus_4),
    .id_inst     (id_inst),
    .id_valid    (id_valid)
`ifdef IFID_BUBBLE_CNT_EN
    ,
    .bubble_cnt  (bubble_cnt)
`endif
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic [31:0] bub;
  } bundle_t;

  bundle_t     exp_q[$];
  bundle_t     waiting[$];
  bundle_t     m_out;
  bundle_t     mon_e;
  bit          m_pend;
  logic [31:0] m_pc, m_pc4, m_bub;
  bit          rdata_has;
  logic [31:0] rdata_next;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out     = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    waiting.delete();
    m_pend    = 0;
    m_pc      = 0;
    m_pc4     = 0;
    m_bub     = 0;
    rdata_has = 0;
  endtask

  // One cycle: drive inputs at negedge, predict what id_* shows after the next posedge.
  task automatic step(input bit ice, input logic [31:0] pc, input logic [31:0] data,
                      input bit stl, input bit fl);
    bundle_t ret;
    bundle_t e;
    @(negedge clk);
    if_ice       = ice;
    if_pc        = pc;
    if_pc_plus_4 = pc + 32'd4;
    stall        = {1'($urandom), stl, 2'($urandom)};
    flush        = fl;
    inst_rdata   = rdata_has ? rdata_next : $urandom;
    ret          = '{1'b1, m_pc, m_pc4, inst_rdata, 32'h0};
    if (fl) begin
      waiting.delete();
      m_out.v    = 1'b0;
      m_out.inst = 32'h0;
    end else if (!stl) begin
      if (waiting.size() > 0) m_out = waiting.pop_front();
      else if (m_pend) m_out = ret;
      else begin
        m_out.v    = 1'b0;
        m_out.inst = 32'h0;
      end
    end else if (m_pend) begin
      if (waiting.size() == 0) waiting.push_back(ret);
      else begin
        failures++;
        $display("FAIL protocol fetch_while_hold_full actual=1 required=0 t=%0t", $time);
      end
    end
    if (!stl && !m_out.v && m_bub != 32'hFFFF_FFFF) m_bub++;
    e     = m_out;
    e.bub = m_bub;
    exp_q.push_back(e);
    m_pend = ice && !fl;
    if (m_pend) begin
      m_pc  = pc;
      m_pc4 = pc + 32'd4;
    end
    rdata_has  = m_pend;
    rdata_next = data;
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("id_valid", {31'h0, id_valid}, {31'h0, mon_e.v});
      chk("id_inst", id_inst, mon_e.inst);
      chk("id_pc", id_pc, mon_e.pc);
      chk("id_pc_plus_4", id_pc_plus_4, mon_e.pc4);
`ifdef IFID_BUBBLE_CNT_EN
      chk("bubble_cnt", bubble_cnt, mon_e.bub);
`endif
    end
  end

  task automatic idle_inputs();
    if_ice = 0; if_pc = 0; if_pc_plus_4 = 0; inst_rdata = 0; stall = 0; flush = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    chk("reset_valid", {31'h0, id_valid}, 32'h0);
    chk("reset_inst", id_inst, 32'h0);
    chk("reset_pc", id_pc, 32'h0);
    chk("reset_pc4", id_pc_plus_4, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // straight line, then two bubbles
    step(1, 32'h0, 32'h11, 0, 0);
    step(1, 32'h4, 32'h22, 0, 0);
    step(1, 32'h8, 32'h33, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    // decode stall while the second fetch returns
    step(1, 32'h0, 32'h11, 0, 0);
    step(1, 32'h4, 32'h22, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    // flush with a fetch in flight
    step(1, 32'h10, 32'hDEAD, 0, 0);
    step(0, 32'h0, 32'h0, 0, 1);
    step(1, 32'h380, 32'h3800, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    // flush while the hold buffer is full
    step(1, 32'h50, 32'h500, 0, 0);
    step(1, 32'h54, 32'h540, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 1);
    step(1, 32'h60, 32'h600, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    // asynchronous reset while id_valid=1
    step(1, 32'h70, 32'h700, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0);
    @(posedge clk);
    #2;
    chk("pre_reset_valid", {31'h0, id_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("async_reset_valid", {31'h0, id_valid}, 32'h0);
    chk("async_reset_inst", id_inst, 32'h0);
    chk("async_reset_pc", id_pc, 32'h0);
    exp_q.delete();
    model_reset();
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic; fetches only issue when decode is not stalled
    for (int i = 0; i < 1500; i++) begin
      bit stl, fl, ice;
      stl = ($urandom_range(0, 3) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      ice = !stl && ($urandom_range(0, 3) != 0);
      step(ice, $urandom & 32'hFFFF_FFFC, $urandom, stl, fl);
    end
    for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h0, 0, 0);

    @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifid_buffer.md
Name: ifid_buffer

Overview:
- IF-to-ID pipeline boundary. Captures the fetch PC from the fetch stage and the instruction returned by the synchronous instruction RAM one cycle later, then presents the aligned {pc, pc_plus_4, inst, valid} bundle to the decode stage.
- A one-entry hold buffer keeps an instruction that returns while decode is stalled, so it is not lost or re-fetched.
- Drops in-flight fetches on a pipeline flush.

Parameters:
- ADDR_W, 32, instruction address width.
- INST_W, 32, instruction word width.
- NOP_INST, 32'h0000_0000, instruction value driven to decode when no valid instruction is present.

Ports:
- cpu_clk_50M  in  1  CPU clock; all state updates on its rising edge.
- cpu_rst  in  1  asynchronous, active-high reset.
- if_ice  in  1  fetch-stage instruction RAM enable; 1 means a fetch is issued this cycle.
- if_pc  in  ADDR_W  PC of the fetch issued this cycle.
- if_pc_plus_4  in  ADDR_W  if_pc + 4 from the fetch stage.
- inst_rdata  in  INST_W  instruction RAM read data, valid the cycle after if_ice=1.
- stall  in  4  pipeline stall vector; bit 2 = decode stall, bits 0/1 are consumed upstream and ignored here.
- flush  in  1  exception flush; discards all fetch-side state.
- id_pc  out  ADDR_W  PC presented to decode.
- id_pc_plus_4  out  ADDR_W  PC+4 presented to decode.
- id_inst  out  INST_W  instruction presented to decode.
- id_valid  out  1  id_* bundle holds a real instruction.

Behaviour:
- Reset (async, cpu_rst=1): id_valid=0, id_pc=0, id_pc_plus_4=0, id_inst=NOP_INST, all internal state cleared, state=IDLE.
- Request tracking:
  - On each edge with if_ice=1 and flush=0, latch req_pc and req_pc4 from the inputs and set req_pend=1.
  - Otherwise clear req_pend.
  - When req_pend=1, inst_rdata in the following cycle belongs to req_pc.
- States:
  - IDLE: no valid output.
  - RUN: output valid, decode accepting.
  - HOLD: output valid, decode stalled, with a returned instruction parked in the hold buffer.
  - DROP: one-cycle discard of RAM data after a flush.
- Advance rule: the output register loads when stall[2]=0.
  - Load source priority: hold buffer if full; else {req_pc, req_pc4, inst_rdata} if req_pend; else a bubble (id_valid=0, id_inst=NOP_INST, PC registers unchanged).
- Stall rule (stall[2]=1): the output register holds.
  - If req_pend=1 and the hold buffer is empty, capture the returning data into the hold buffer and enter HOLD.
  - If req_pend=1 and the hold buffer is full, this is a protocol violation (the fetch stage must not issue while decode is stalled). Keep the older entry; the assertion in the bench flags it.
- Transitions:
  - IDLE -> RUN on load of a valid instruction.
  - RUN -> HOLD on capture during stall.
  - HOLD -> RUN when stall[2] falls; the buffer drains into the output in that cycle, then is empty.
  - RUN -> IDLE on a bubble load.
- Flush (highest priority, same edge):
  - id_valid=0, id_inst=NOP_INST, hold buffer cleared.
  - If req_pend=1, enter DROP; the next cycle's inst_rdata is ignored, then go to IDLE.
  - A flush while stalled still clears everything.
- Latency: fetch issue at edge N → instruction on id_* after edge N+1 when no stall.
- Throughput: one instruction per cycle.
- id_pc_plus_4 is always req_pc4 of the same instruction and is never recomputed here.

Optional Feature:
- Macro: IFID_BUBBLE_CNT_EN.
- Defined: adds output bubble_cnt (32 bits). It increments on every edge where decode is not stalled and id_valid loads 0. It clears on reset, saturates at 32'hFFFF_FFFF, and is unaffected by flush except that a flush-induced bubble counts.
- Undefined: no port, no counter logic.

Test Plan:
- Reset mid-run: assert cpu_rst asynchronously while id_valid=1 -> id_valid=0 and id_inst=32'h0 immediately, before the next edge.
- Straight line: fetches at pc 0x0,0x4,0x8 on consecutive cycles with rdata 0x11,0x22,0x33 -> id_pc/id_inst show 0x0/0x11, 0x4/0x22, 0x8/0x33 one cycle later each, and id_pc_plus_4 = 0x4,0x8,0xC.
- Decode stall: stall[2]=1 for 3 cycles while 0x4/0x22 is returning -> id_* holds 0x0/0x11; after release, 0x4/0x22 appears on the next edge with no re-fetch.
- Flush in flight: fetch 0x10 issued, flush=1 on the next edge, rdata 0xDEAD -> 0xDEAD never appears, id_valid=0 for 2 cycles, then a fetch at 0x380 appears normally.
- Bubble: if_ice=0 for 2 cycles -> id_valid=0 and id_inst=0 for 2 cycles, id_pc unchanged; with IFID_BUBBLE_CNT_EN, bubble_cnt increases by 2.
- Flush during HOLD: hold buffer full, flush=1 -> buffer discarded; the next valid output is the post-flush fetch.
